// File: rtl/flag_rename_pkg.sv
// -----------------------------------------------------------------------------
// flag_rename_pkg
// Shared constants and helpers for the flag rename free-list controller.
//   FLAG_ENTRY_N : number of flag rename entries (and free-list depth)
//   FLAG_ID_W    : flag register name width
//   FLAG_CNT_W   : free-list occupancy width (0..FLAG_ENTRY_N)
//   onehot_to_idx: converts a one-hot entry vector into its index
// -----------------------------------------------------------------------------
package flag_rename_pkg;

  localparam int FLAG_ENTRY_N = 16;
  localparam int FLAG_ID_W    = 4;
  localparam int FLAG_CNT_W   = 5;

  // OR-reduction encoder; only meaningful for one-hot (or all-zero) input.
  function automatic logic [FLAG_ID_W-1:0] onehot_to_idx(input logic [FLAG_ENTRY_N-1:0] oh);
    logic [FLAG_ID_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < FLAG_ENTRY_N; i++) begin
      if (oh[i]) idx = idx | FLAG_ID_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/flag_rename_freelist_ctrl_if.sv
// -----------------------------------------------------------------------------
// flag_rename_freelist_ctrl_if
// Bundles the entry-side and rename-side signals of the free-list controller.
//   iREMOVE_VALID                       : pipeline flush
//   iENTRY_REQ / oENTRY_REGIST_ACK      : per-entry request / one-hot ack
//   iALLOC_x_REQ / oALLOC_x_VALID/REGNAME : two rename allocation slots
//   oFREELIST_COUNT / oFREELIST_EMPTY   : free-list occupancy status
// Modports: slave = controller view, master = requester/environment view.
// -----------------------------------------------------------------------------
interface flag_rename_freelist_ctrl_if
  import flag_rename_pkg::*;
#(
  parameter int ENTRY_N = FLAG_ENTRY_N,
  parameter int ID_W    = FLAG_ID_W
) ();

  logic               iREMOVE_VALID;
  logic [ENTRY_N-1:0] iENTRY_REQ;
  logic [ENTRY_N-1:0] oENTRY_REGIST_ACK;
  logic               iALLOC_0_REQ;
  logic               iALLOC_1_REQ;
  logic               oALLOC_0_VALID;
  logic               oALLOC_1_VALID;
  logic [ID_W-1:0]    oALLOC_0_REGNAME;
  logic [ID_W-1:0]    oALLOC_1_REGNAME;
  logic [ID_W:0]      oFREELIST_COUNT;
  logic               oFREELIST_EMPTY;

  modport slave (
    input  iREMOVE_VALID, iENTRY_REQ, iALLOC_0_REQ, iALLOC_1_REQ,
    output oENTRY_REGIST_ACK, oALLOC_0_VALID, oALLOC_1_VALID,
           oALLOC_0_REGNAME, oALLOC_1_REGNAME, oFREELIST_COUNT, oFREELIST_EMPTY
  );

  modport master (
    output iREMOVE_VALID, iENTRY_REQ, iALLOC_0_REQ, iALLOC_1_REQ,
    input  oENTRY_REGIST_ACK, oALLOC_0_VALID, oALLOC_1_VALID,
           oALLOC_0_REGNAME, oALLOC_1_REGNAME, oFREELIST_COUNT, oFREELIST_EMPTY
  );

endinterface

// File: rtl/flag_freelist_fifo.sv
// -----------------------------------------------------------------------------
// flag_freelist_fifo
// 16 x 4 free-list FIFO: one push and up to two pops per cycle.
//   clk_i, rst_i   : clock, synchronous active-high reset
//   clr_i          : synchronous clear of pointers and count (flush)
//   push_i/push_id_i : write one flag name at the tail
//   pop_cnt_i      : number of names consumed this cycle (0..2)
//   head_o/head_next_o : oldest and second-oldest entries
//   count_o        : occupancy 0..16
// -----------------------------------------------------------------------------
module flag_freelist_fifo
  import flag_rename_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clr_i,
  input  logic                 push_i,
  input  logic [FLAG_ID_W-1:0] push_id_i,
  input  logic [1:0]           pop_cnt_i,
  output logic [FLAG_ID_W-1:0] head_o,
  output logic [FLAG_ID_W-1:0] head_next_o,
  output logic [FLAG_CNT_W-1:0] count_o
);

  logic [FLAG_ID_W-1:0]  mem_q [FLAG_ENTRY_N];
  logic [FLAG_ID_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [FLAG_ID_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [FLAG_ID_W-1:0]  rd_ptr_nxt;
  logic [FLAG_CNT_W-1:0] count_q, count_d;

  // Pointers are exactly FLAG_ID_W bits, so they wrap mod 16 by themselves.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    wr_ptr_d = wr_ptr_q + FLAG_ID_W'(push_i);
    rd_ptr_d = rd_ptr_q + FLAG_ID_W'(pop_cnt_i);
    count_d  = count_q + FLAG_CNT_W'(push_i) - FLAG_CNT_W'(pop_cnt_i);
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    // NOTE: state registers use non-blocking assignment so all flops update together.
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage has no reset; count_o qualifies which slots hold valid names.
  always_ff @(posedge clk_i) begin
    if (push_i && !clr_i) mem_q[wr_ptr_q] <= push_id_i;
  end

  assign rd_ptr_nxt  = rd_ptr_q + FLAG_ID_W'(1);
  assign head_o      = mem_q[rd_ptr_q];
  assign head_next_o = mem_q[rd_ptr_nxt];
  assign count_o     = count_q;

endmodule

// File: rtl/flag_rename_freelist_ctrl.sv
// -----------------------------------------------------------------------------
// flag_rename_freelist_ctrl
// Free-list controller for the 16 flag rename entries. Selects one requesting
// entry per cycle, acks it for one cycle, pushes its ID into a free-list FIFO
// and hands up to two flag names per cycle to the rename stage.
//   iCLOCK      : clock
//   iRESET_SYNC : synchronous active-high reset
//   bus         : flag_rename_freelist_ctrl_if.slave (entry req/ack,
//                 two allocation slots, occupancy, flush)
// Build option: MIST1032SA_FLAG_FREELIST_RR_EN selects round-robin arbitration
// (pointer advances to winner+1); undefined gives fixed lowest-index priority.
// -----------------------------------------------------------------------------
module flag_rename_freelist_ctrl
  import flag_rename_pkg::*;
#(
  parameter int ENTRY_N = FLAG_ENTRY_N,
  parameter int ID_W    = FLAG_ID_W
) (
  input logic                         iCLOCK,
  input logic                         iRESET_SYNC,
  flag_rename_freelist_ctrl_if.slave  bus
);

  logic               flush;
  logic [ENTRY_N-1:0] eff_req;
  logic [ENTRY_N-1:0] grant;
  logic [ID_W-1:0]    win_idx;
  logic [ENTRY_N-1:0] ack_q, ack_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic               sel_v_q, sel_v_d;

  logic [ID_W-1:0]       fifo_head, fifo_head_next;
  logic [FLAG_CNT_W-1:0] fifo_count;
  logic [1:0]            pop_cnt;
  logic                  alloc0_valid, alloc1_valid;
  logic [ID_W-1:0]       alloc0_name, alloc1_name;

  assign flush = bus.iREMOVE_VALID;

  // The entry under ack still shows its request this cycle; mask it out so
  // it is not granted twice.
  assign eff_req = bus.iENTRY_REQ & ~ack_q;

`ifdef MIST1032SA_FLAG_FREELIST_RR_EN
  logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [2*ENTRY_N-1:0] req_dbl;
  logic [ENTRY_N-1:0]   req_rot, rot_oh;

  // Rotate requests so the pointer position becomes bit 0, pick the lowest
  // set bit, then add the pointer back to get the absolute winner.
  always_comb begin
    req_dbl  = {eff_req, eff_req};
    req_rot  = req_dbl[rr_ptr_q +: ENTRY_N];
    rot_oh   = req_rot & (-req_rot);
    win_idx  = onehot_to_idx(rot_oh) + rr_ptr_q;
    grant    = (|eff_req) ? (ENTRY_N'(1) << win_idx) : '0;
    rr_ptr_d = rr_ptr_q;
    if (|eff_req) rr_ptr_d = win_idx + ID_W'(1);
    if (flush)    rr_ptr_d = '0;
  end

  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) rr_ptr_q <= '0;
    else             rr_ptr_q <= rr_ptr_d;
  end
`else
  // Fixed priority: isolate the lowest set request bit.
  always_comb begin
    grant   = eff_req & (-eff_req);
    win_idx = onehot_to_idx(grant);
  end
`endif

  // Select stage: flush wins over a new grant.
  always_comb begin
    ack_d   = grant;
    id_d    = win_idx;
    sel_v_d = |eff_req;
    if (flush) begin
      ack_d   = '0;
      id_d    = '0;
      sel_v_d = 1'b0;
    end
  end

  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      ack_q   <= '0;
      id_q    <= '0;
      sel_v_q <= 1'b0;
    end else begin
      ack_q   <= ack_d;
      id_q    <= id_d;
      sel_v_q <= sel_v_d;
    end
  end

  // Push stage: the ID enters the FIFO at the end of its ack cycle, so it
  // cannot be allocated before the entry has seen the ack.
  flag_freelist_fifo u_fifo (
    .clk_i       (iCLOCK),
    .rst_i       (iRESET_SYNC),
    .clr_i       (flush),
    .push_i      (sel_v_q & ~flush),
    .push_id_i   (id_q),
    .pop_cnt_i   (pop_cnt),
    .head_o      (fifo_head),
    .head_next_o (fifo_head_next),
    .count_o     (fifo_count)
  );

  // Slot 1 takes the second name only when slot 0 is also consuming; on its
  // own it takes the head. Names read as 0 when not valid.
  always_comb begin
    alloc0_valid = 1'b0;
    alloc1_valid = 1'b0;
    alloc0_name  = '0;
    alloc1_name  = '0;
    if (!flush) begin
      alloc0_valid = (fifo_count != '0);
      if (bus.iALLOC_0_REQ) alloc1_valid = (fifo_count > FLAG_CNT_W'(1));
      else                  alloc1_valid = (fifo_count != '0);
    end
    if (alloc0_valid) alloc0_name = fifo_head;
    if (alloc1_valid) alloc1_name = bus.iALLOC_0_REQ ? fifo_head_next : fifo_head;
  end

  assign pop_cnt = {1'b0, bus.iALLOC_0_REQ & alloc0_valid}
                 + {1'b0, bus.iALLOC_1_REQ & alloc1_valid};

  assign bus.oENTRY_REGIST_ACK = flush ? '0 : ack_q;
  assign bus.oALLOC_0_VALID    = alloc0_valid;
  assign bus.oALLOC_1_VALID    = alloc1_valid;
  assign bus.oALLOC_0_REGNAME  = alloc0_name;
  assign bus.oALLOC_1_REGNAME  = alloc1_name;
  assign bus.oFREELIST_COUNT   = fifo_count;
  assign bus.oFREELIST_EMPTY   = (fifo_count == '0);

endmodule

// File: tb/tb_flag_rename_freelist_ctrl.sv
// -----------------------------------------------------------------------------
// tb_flag_rename_freelist_ctrl
// Directed self-checking bench for flag_rename_freelist_ctrl. Inputs change
// 1 ns after the rising edge; outputs are sampled before the next edge.
// -----------------------------------------------------------------------------
module tb_flag_rename_freelist_ctrl;
  import flag_rename_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  flag_rename_freelist_ctrl_if bus ();

  flag_rename_freelist_ctrl dut (
    .iCLOCK      (clk),
    .iRESET_SYNC (rst),
    .bus         (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.iREMOVE_VALID = 1'b0;
    bus.iENTRY_REQ    = '0;
    bus.iALLOC_0_REQ  = 1'b0;
    bus.iALLOC_1_REQ  = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Entry protocol: request for one cycle, keep it during the ack cycle,
  // drop it afterwards. Returns in the cycle the ID is allocatable.
  task automatic reg_one(input int id);
    logic [15:0] oh;
    oh = 16'(1) << id;
    bus.iENTRY_REQ = oh;
    tick();
    n_cmp++;
    if (bus.oENTRY_REGIST_ACK !== oh) begin
      n_err++;
      $display("FAIL reg_ack id=%0d: got %h expected %h", id, bus.oENTRY_REGIST_ACK, oh);
    end
    tick();
    bus.iENTRY_REQ = '0;
  endtask

  task automatic test_reset();
    bus.iENTRY_REQ   = 16'hFFFF;
    bus.iALLOC_0_REQ = 1'b1;
    bus.iALLOC_1_REQ = 1'b1;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    bus.iENTRY_REQ = '0;
    #1;
    n_cmp++;
    if ({bus.oENTRY_REGIST_ACK, bus.oALLOC_0_VALID, bus.oALLOC_0_REGNAME, bus.oALLOC_1_VALID,
         bus.oALLOC_1_REGNAME, bus.oFREELIST_COUNT, bus.oFREELIST_EMPTY} !==
        {16'h0000, 1'b0, 4'h0, 1'b0, 4'h0, 5'd0, 1'b1}) begin
      n_err++;
      $display("FAIL reset_state: ack=%h v0=%b n0=%h v1=%b n1=%h cnt=%0d empty=%b expected all 0, empty=1",
               bus.oENTRY_REGIST_ACK, bus.oALLOC_0_VALID, bus.oALLOC_0_REGNAME, bus.oALLOC_1_VALID,
               bus.oALLOC_1_REGNAME, bus.oFREELIST_COUNT, bus.oFREELIST_EMPTY);
    end
    idle_inputs();
  endtask

  // All 16 entries request; fixed priority gives acks 0..15 in cycles 1..16
  // and count 16 in cycle 17. Then drain two per cycle across the wrap.
  task automatic test_fill_drain();
    logic [15:0] reqs, exp_ack;
    do_reset();
    reqs = 16'hFFFF;
    bus.iENTRY_REQ = reqs;
    for (int k = 1; k <= 17; k++) begin
      tick();
      exp_ack = (k <= 16) ? (16'(1) << (k - 1)) : 16'h0000;
      n_cmp++;
      if ({bus.oENTRY_REGIST_ACK, bus.oFREELIST_COUNT} !== {exp_ack, 5'(k - 1)}) begin
        n_err++;
        $display("FAIL fill cycle %0d: ack=%h cnt=%0d expected ack=%h cnt=%0d",
                 k, bus.oENTRY_REGIST_ACK, bus.oFREELIST_COUNT, exp_ack, k - 1);
      end
      bus.iENTRY_REQ = reqs;
      reqs = reqs & ~exp_ack;
    end
    n_cmp++;
    if (bus.oFREELIST_EMPTY !== 1'b0) begin
      n_err++;
      $display("FAIL full_empty_flag: got %b expected 0", bus.oFREELIST_EMPTY);
    end
    bus.iENTRY_REQ   = '0;
    bus.iALLOC_0_REQ = 1'b1;
    bus.iALLOC_1_REQ = 1'b1;
    for (int j = 0; j < 8; j++) begin
      #1;
      n_cmp++;
      if ({bus.oALLOC_0_VALID, bus.oALLOC_0_REGNAME, bus.oALLOC_1_VALID, bus.oALLOC_1_REGNAME,
           bus.oFREELIST_COUNT} !== {1'b1, 4'(2 * j), 1'b1, 4'(2 * j + 1), 5'(16 - 2 * j)}) begin
        n_err++;
        $display("FAIL drain step %0d: v0=%b n0=%0d v1=%b n1=%0d cnt=%0d expected 1 %0d 1 %0d cnt=%0d",
                 j, bus.oALLOC_0_VALID, bus.oALLOC_0_REGNAME, bus.oALLOC_1_VALID,
                 bus.oALLOC_1_REGNAME, bus.oFREELIST_COUNT, 2 * j, 2 * j + 1, 16 - 2 * j);
      end
      tick();
    end
    bus.iALLOC_0_REQ = 1'b0;
    bus.iALLOC_1_REQ = 1'b0;
    #1;
    n_cmp++;
    if ({bus.oFREELIST_COUNT, bus.oFREELIST_EMPTY, bus.oALLOC_0_VALID} !== {5'd0, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL drained: cnt=%0d empty=%b v0=%b expected 0 1 0",
               bus.oFREELIST_COUNT, bus.oFREELIST_EMPTY, bus.oALLOC_0_VALID);
    end
    // Pointers have wrapped; a new ID must appear at the head.
    reg_one(11);
    n_cmp++;
    if ({bus.oALLOC_0_VALID, bus.oALLOC_0_REGNAME, bus.oFREELIST_COUNT} !== {1'b1, 4'd11, 5'd1}) begin
      n_err++;
      $display("FAIL wrap_push: v0=%b n0=%0d cnt=%0d expected 1 11 1",
               bus.oALLOC_0_VALID, bus.oALLOC_0_REGNAME, bus.oFREELIST_COUNT);
    end
  endtask

  // Request still high during the ack cycle gives one ack and one push;
  // the name is allocatable two cycles after the request.
  task automatic test_single_ack();
    do_reset();
    bus.iENTRY_REQ = 16'h0008;
    tick();
    n_cmp++;
    if ({bus.oENTRY_REGIST_ACK, bus.oFREELIST_COUNT, bus.oALLOC_0_VALID} !== {16'h0008, 5'd0, 1'b0}) begin
      n_err++;
      $display("FAIL single_ack_pulse: ack=%h cnt=%0d v0=%b expected 0008 0 0",
               bus.oENTRY_REGIST_ACK, bus.oFREELIST_COUNT, bus.oALLOC_0_VALID);
    end
    tick();
    bus.iENTRY_REQ = '0;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_cmp++;
      if ({bus.oENTRY_REGIST_ACK, bus.oFREELIST_COUNT, bus.oALLOC_0_VALID, bus.oALLOC_0_REGNAME} !==
          {16'h0000, 5'd1, 1'b1, 4'd3}) begin
        n_err++;
        $display("FAIL single_ack_after %0d: ack=%h cnt=%0d v0=%b n0=%0d expected 0000 1 1 3",
                 k, bus.oENTRY_REGIST_ACK, bus.oFREELIST_COUNT, bus.oALLOC_0_VALID, bus.oALLOC_0_REGNAME);
      end
      tick();
    end
  endtask

  task automatic test_alloc_pair();
    do_reset();
    reg_one(2);
    reg_one(7);
    reg_one(9);
    bus.iALLOC_0_REQ = 1'b1;
    bus.iALLOC_1_REQ = 1'b1;
    #1;
    n_cmp++;
    if ({bus.oALLOC_0_VALID, bus.oALLOC_0_REGNAME, bus.oALLOC_1_VALID, bus.oALLOC_1_REGNAME,
         bus.oFREELIST_COUNT} !== {1'b1, 4'd2, 1'b1, 4'd7, 5'd3}) begin
      n_err++;
      $display("FAIL alloc_pair: v0=%b n0=%0d v1=%b n1=%0d cnt=%0d expected 1 2 1 7 cnt=3",
               bus.oALLOC_0_VALID, bus.oALLOC_0_REGNAME, bus.oALLOC_1_VALID,
               bus.oALLOC_1_REGNAME, bus.oFREELIST_COUNT);
    end
    tick();
    bus.iALLOC_0_REQ = 1'b0;
    bus.iALLOC_1_REQ = 1'b0;
    #1;
    n_cmp++;
    if ({bus.oALLOC_0_VALID, bus.oALLOC_0_REGNAME, bus.oFREELIST_COUNT} !== {1'b1, 4'd9, 5'd1}) begin
      n_err++;
      $display("FAIL alloc_pair_after: v0=%b n0=%0d cnt=%0d expected 1 9 1",
               bus.oALLOC_0_VALID, bus.oALLOC_0_REGNAME, bus.oFREELIST_COUNT);
    end
  endtask

  // count==1 boundary: slot 1 alone takes the head; with both slots asking,
  // slot 0 wins and slot 1 is not valid.
  task automatic test_alloc_single();
    do_reset();
    reg_one(5);
    bus.iALLOC_1_REQ = 1'b1;
    #1;
    n_cmp++;
    if ({bus.oALLOC_0_VALID, bus.oALLOC_1_VALID, bus.oALLOC_1_REGNAME} !== {1'b1, 1'b1, 4'd5}) begin
      n_err++;
      $display("FAIL alloc1_only: v0=%b v1=%b n1=%0d expected 1 1 5",
               bus.oALLOC_0_VALID, bus.oALLOC_1_VALID, bus.oALLOC_1_REGNAME);
    end
    tick();
    bus.iALLOC_1_REQ = 1'b0;
    #1;
    n_cmp++;
    if ({bus.oFREELIST_COUNT, bus.oFREELIST_EMPTY} !== {5'd0, 1'b1}) begin
      n_err++;
      $display("FAIL alloc1_only_after: cnt=%0d empty=%b expected 0 1",
               bus.oFREELIST_COUNT, bus.oFREELIST_EMPTY);
    end
    reg_one(5);
    bus.iALLOC_0_REQ = 1'b1;
    bus.iALLOC_1_REQ = 1'b1;
    #1;
    n_cmp++;
    if ({bus.oALLOC_0_VALID, bus.oALLOC_0_REGNAME, bus.oALLOC_1_VALID} !== {1'b1, 4'd5, 1'b0}) begin
      n_err++;
      $display("FAIL both_at_one: v0=%b n0=%0d v1=%b expected 1 5 0",
               bus.oALLOC_0_VALID, bus.oALLOC_0_REGNAME, bus.oALLOC_1_VALID);
    end
    tick();
    bus.iALLOC_0_REQ = 1'b0;
    bus.iALLOC_1_REQ = 1'b0;
    #1;
    n_cmp++;
    if (bus.oFREELIST_COUNT !== 5'd0) begin
      n_err++;
      $display("FAIL both_at_one_after: cnt=%0d expected 0", bus.oFREELIST_COUNT);
    end
  endtask

  // Push and pop in the same cycle: the pushed name shows up behind the head
  // only in the following cycle.
  task automatic test_back_to_back();
    do_reset();
    reg_one(4);
    bus.iENTRY_REQ = 16'h0040;
    tick();
    bus.iALLOC_0_REQ = 1'b1;
    #1;
    n_cmp++;
    if ({bus.oENTRY_REGIST_ACK, bus.oALLOC_0_VALID, bus.oALLOC_0_REGNAME, bus.oFREELIST_COUNT} !==
        {16'h0040, 1'b1, 4'd4, 5'd1}) begin
      n_err++;
      $display("FAIL push_pop_same: ack=%h v0=%b n0=%0d cnt=%0d expected 0040 1 4 1",
               bus.oENTRY_REGIST_ACK, bus.oALLOC_0_VALID, bus.oALLOC_0_REGNAME, bus.oFREELIST_COUNT);
    end
    tick();
    bus.iALLOC_0_REQ = 1'b0;
    bus.iENTRY_REQ   = '0;
    #1;
    n_cmp++;
    if ({bus.oALLOC_0_VALID, bus.oALLOC_0_REGNAME, bus.oFREELIST_COUNT} !== {1'b1, 4'd6, 5'd1}) begin
      n_err++;
      $display("FAIL push_pop_after: v0=%b n0=%0d cnt=%0d expected 1 6 1",
               bus.oALLOC_0_VALID, bus.oALLOC_0_REGNAME, bus.oFREELIST_COUNT);
    end
  endtask

  task automatic test_flush();
    do_reset();
    for (int id = 0; id < 6; id++) reg_one(id);
    bus.iENTRY_REQ = 16'h0400;
    tick();
    bus.iREMOVE_VALID = 1'b1;
    bus.iALLOC_0_REQ  = 1'b1;
    bus.iALLOC_1_REQ  = 1'b1;
    #1;
    n_cmp++;
    if ({bus.oENTRY_REGIST_ACK, bus.oALLOC_0_VALID, bus.oALLOC_1_VALID, bus.oFREELIST_COUNT} !==
        {16'h0000, 1'b0, 1'b0, 5'd6}) begin
      n_err++;
      $display("FAIL flush_cycle: ack=%h v0=%b v1=%b cnt=%0d expected 0000 0 0 6",
               bus.oENTRY_REGIST_ACK, bus.oALLOC_0_VALID, bus.oALLOC_1_VALID, bus.oFREELIST_COUNT);
    end
    tick();
    idle_inputs();
    #1;
    n_cmp++;
    if ({bus.oFREELIST_COUNT, bus.oFREELIST_EMPTY, bus.oENTRY_REGIST_ACK} !== {5'd0, 1'b1, 16'h0000}) begin
      n_err++;
      $display("FAIL flush_after: cnt=%0d empty=%b ack=%h expected 0 1 0000",
               bus.oFREELIST_COUNT, bus.oFREELIST_EMPTY, bus.oENTRY_REGIST_ACK);
    end
    tick();
    n_cmp++;
    if ({bus.oFREELIST_COUNT, bus.oFREELIST_EMPTY} !== {5'd0, 1'b1}) begin
      n_err++;
      $display("FAIL flush_no_push: cnt=%0d empty=%b expected 0 1",
               bus.oFREELIST_COUNT, bus.oFREELIST_EMPTY);
    end
  endtask

  // Entries 0, 1 and 4 hold requests. Fixed priority starves entry 4;
  // round-robin reaches it on the third grant.
  task automatic test_arbitration();
    logic [15:0] exp_ack [5];
`ifdef MIST1032SA_FLAG_FREELIST_RR_EN
    exp_ack[0] = 16'h0001; exp_ack[1] = 16'h0002; exp_ack[2] = 16'h0010;
    exp_ack[3] = 16'h0001; exp_ack[4] = 16'h0002;
`else
    exp_ack[0] = 16'h0001; exp_ack[1] = 16'h0002; exp_ack[2] = 16'h0001;
    exp_ack[3] = 16'h0002; exp_ack[4] = 16'h0001;
`endif
    do_reset();
    bus.iENTRY_REQ = 16'h0013;
    for (int k = 0; k < 5; k++) begin
      tick();
      n_cmp++;
      if (bus.oENTRY_REGIST_ACK !== exp_ack[k]) begin
        n_err++;
        $display("FAIL arb_grant %0d: got %h expected %h", k, bus.oENTRY_REGIST_ACK, exp_ack[k]);
      end
    end
    bus.iENTRY_REQ = '0;
    do_reset();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_fill_drain();
    test_single_ack();
    test_alloc_pair();
    test_alloc_single();
    test_back_to_back();
    test_flush();
    test_arbitration();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
